conv_window_scheduler: RTL and testbench
========================================

# conv_window_scheduler

Controller that sequences 3x3 zero-padded window extraction over a ROWS x COLS 8-bit image held in a single-port synchronous pixel RAM. It walks every pixel as a window centre in raster order and issues one RAM read per in-bounds tap. It substitutes 0 for out-of-bounds taps. Each completed window is handed to the downstream kernel engine over a valid/ready handshake. It sits between the frame buffer RAM and the convolution MAC stage and replaces direct whole-array indexing of the image.

## Interface
- ROWS, 512, image height in pixels (>= 2)
- COLS, 512, image width in pixels (>= 2)
- AW, $clog2(ROWS*COLS), pixel RAM address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to process one frame; ignored unless IDLE
- busy  out  1  high from the cycle after accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last window handshake
- mem_en  out  1  RAM read enable
- mem_addr  out  AW  RAM read address = row*COLS + col
- mem_rdata  in  8  RAM read data, valid exactly 1 cycle after mem_en
- win_valid  out  1  window available
- win_ready  in  1  downstream accepts window
- win_pixels  out  72  tap k at bits [8k+7:8k], k = 3*i+j; i = row offset (0 above, 2 below), j = col offset (0 left, 2 right)
- win_row  out  $clog2(ROWS)  centre row of presented window
- win_col  out  $clog2(COLS)  centre col of presented window

## Operation
- States: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE: start=1 -> FETCH with centre (r,c)=(0,0), tap t=0, window register cleared.
- FETCH: one tap per cycle, t=0..8.
  - Source is (r+i-1, c+j-1).
  - In bounds: mem_en=1 and mem_addr=source address.
  - Out of bounds: mem_en=0; tap is written 0 on the following cycle.
  - t=8 -> DRAIN.
- Capture pipeline: tap index and pad flag are delayed 1 cycle. On the next cycle, tap k is written with mem_rdata, or with 0 if padded.
- DRAIN: captures tap 8 -> PRESENT.
- PRESENT:
  - win_valid=1; win_pixels, win_row and win_col are held stable.
  - No mem_en while waiting.
  - On win_valid&&win_ready: if (r,c)=(ROWS-1,COLS-1) -> DONE; else advance c (wrapping to 0 with r+1 at c=COLS-1) and go to FETCH with t=0.
- DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Address arithmetic is exact, with no wrap into adjacent rows. Column -1 and column COLS are pads, never row-1/COLS-1 aliases.
- start while busy has no effect.
- rst in any state: immediately IDLE on the next edge, all counters 0, outputs at reset values. Any in-flight RAM data is discarded.

## Timing
- Reset values: busy=0, frame_done=0, mem_en=0, mem_addr=0, win_valid=0, win_pixels=0, win_row=0, win_col=0.
- start sampled in cycle 0 -> first mem_en (if in bounds) in cycle 1.
- Window cycle: 9 FETCH + 1 DRAIN + >=1 PRESENT = 11 cycles minimum per window with win_ready held high.
- win_valid rises in the cycle after DRAIN.
- After handshake, the next FETCH starts the following cycle; win_valid is low for at least 10 cycles.
- frame_done pulses in the cycle after the final handshake; busy falls in the same cycle.
- Frame latency with win_ready=1: 11*ROWS*COLS + 2 cycles from start to frame_done.

## Test plan
Benches use ROWS=4, COLS=5, with RAM contents pixel(row,col) = row*5+col+1.

- Reset -> all outputs 0; start during rst has no effect; rst released with no start keeps the block IDLE indefinitely.
- First window -> win_row=0, win_col=0, win_pixels taps k0..k8 = {0,0,0,0,1,2,0,6,7}, mem_en asserted exactly 4 times, win_valid at cycle 11 after start.
- Interior window (1,1) -> taps {1,2,3,6,7,8,11,12,13}.
- Corner window (3,4) -> taps {14,15,0,19,20,0,0,0,0}.
- Backpressure on window (0,2): win_ready low 5 cycles -> win_pixels and win_row/win_col stable, mem_en=0 throughout; handshake then advances to (0,3).
- Full frame with win_ready=1 -> 20 handshakes in raster order; frame_done high for exactly one cycle, 2+11*20 cycles after start.
  - A start pulse mid-frame is ignored.
  - rst asserted after the 7th handshake returns the block to IDLE; the next start restarts at (0,0).

Source files
------------

// File: rtl/conv_window_scheduler.sv
// 3x3 zero-padded window sequencer: walks every pixel as a window centre in raster order,
// reads in-bounds taps from a 1-cycle-latency pixel RAM and presents each window over valid/ready.
module conv_window_scheduler #(
   parameter int ROWS = 512,
   parameter int COLS = 512,
   parameter int AW   = $clog2(ROWS*COLS),
   localparam int RW  = $clog2(ROWS),
   localparam int CW  = $clog2(COLS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   output logic          busy_o,
   output logic          frame_done_o,
   output logic          mem_en_o,
   output logic [AW-1:0] mem_addr_o,
   input  logic [7:0]    mem_rdata_i,
   output logic          win_valid_o,
   input  logic          win_ready_i,
   output logic [71:0]   win_pixels_o,
   output logic [RW-1:0] win_row_o,
   output logic [CW-1:0] win_col_o
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_PRESENT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] c_q, c_d;
   logic [3:0]    tap_q, tap_d;
   logic          mem_en_q, mem_en_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          cap_vld_q, cap_pad_q;
   logic [3:0]    cap_tap_q;
   logic [71:0]   win_q;
   int            src_r, src_c;
   logic          in_bounds;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      tap_d   = tap_q;
      case (state_q)
         S_IDLE: if (start_i) begin
            state_d = S_FETCH;
            r_d     = '0;
            c_d     = '0;
            tap_d   = '0;
         end
         S_FETCH: if (tap_q == 4'd8) state_d = S_DRAIN;
                  else               tap_d   = tap_q + 4'd1;
         S_DRAIN: state_d = S_PRESENT;
         S_PRESENT: if (win_ready_i) begin
            if (r_q == RW'(ROWS-1) && c_q == CW'(COLS-1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FETCH;
               tap_d   = '0;
               if (c_q == CW'(COLS-1)) begin
                  c_d = '0;
                  r_d = r_q + 1'b1;
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            r_d     = '0;
            c_d     = '0;
            tap_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase

      // Read strobe is computed for the upcoming tap so mem_en/mem_addr leave a flop.
      src_r      = int'(r_d) + int'(tap_d) / 3 - 1;
      src_c      = int'(c_d) + int'(tap_d) % 3 - 1;
      in_bounds  = (src_r >= 0) && (src_r < ROWS) && (src_c >= 0) && (src_c < COLS);
      mem_en_d   = (state_d == S_FETCH) && in_bounds;
      mem_addr_d = mem_en_d ? AW'(src_r * COLS + src_c) : mem_addr_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the window register is flop-based and small, so it is reset along with the control state.
         state_q    <= S_IDLE;
         r_q        <= '0;
         c_q        <= '0;
         tap_q      <= '0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
         cap_vld_q  <= 1'b0;
         cap_pad_q  <= 1'b0;
         cap_tap_q  <= '0;
         win_q      <= '0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         c_q        <= c_d;
         tap_q      <= tap_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
         // Tap index and pad flag ride one cycle behind the read to meet the RAM data.
         cap_vld_q  <= (state_q == S_FETCH);
         cap_tap_q  <= tap_q;
         cap_pad_q  <= !mem_en_q;
         if (state_q == S_IDLE && start_i)
            win_q <= '0;
         else if (cap_vld_q)
            win_q[{cap_tap_q, 3'b000} +: 8] <= cap_pad_q ? 8'h00 : mem_rdata_i;
      end
   end

   assign busy_o       = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_PRESENT);
   assign frame_done_o = (state_q == S_DONE);
   assign win_valid_o  = (state_q == S_PRESENT);
   assign mem_en_o     = mem_en_q;
   assign mem_addr_o   = mem_addr_q;
   assign win_pixels_o = win_q;
   assign win_row_o    = r_q;
   assign win_col_o    = c_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler on a 4x5 image whose pixel at address a holds a+1.
module tb_conv_window_scheduler;

   localparam int ROWS = 4;
   localparam int COLS = 5;

   logic        clk = 1'b0;
   logic        rst, start, win_ready;
   logic        busy, frame_done, mem_en, win_valid;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic [71:0] win_pixels;
   logic [1:0]  win_row;
   logic [2:0]  win_col;

   int n_cmp = 0;
   int n_bad = 0;

   conv_window_scheduler #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .busy_o       (busy),
      .frame_done_o (frame_done),
      .mem_en_o     (mem_en),
      .mem_addr_o   (mem_addr),
      .mem_rdata_i  (mem_rdata),
      .win_valid_o  (win_valid),
      .win_ready_i  (win_ready),
      .win_pixels_o (win_pixels),
      .win_row_o    (win_row),
      .win_col_o    (win_col)
   );

   always #5 clk = ~clk;

   // Pixel RAM: pixel(row,col) = row*5+col+1 = address+1, data one cycle after the enable.
   always @(posedge clk) begin
      if (mem_en) begin
         n_cmp++;
         assert (mem_addr < 5'd20) else begin
            n_bad++;
            $error("FAIL ram_addr_range: observed %0d required <20", mem_addr);
         end
         mem_rdata <= 8'(int'(mem_addr) + 1);
      end
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [71:0] pack(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   // Reference window: tap (i,j) is the pixel at (r+i-1, c+j-1) or 0 outside the image.
   function automatic logic [71:0] exp_win(input int r, input int c);
      logic [71:0] v;
      v = '0;
      for (int k = 0; k < 9; k++) begin
         int rr, cc;
         rr = r + k / 3 - 1;
         cc = c + k % 3 - 1;
         if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
            v[8*k +: 8] = 8'(rr * COLS + cc + 1);
      end
      return v;
   endfunction

   task automatic wait_valid(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (win_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check(tag, ok, 1);
   endtask

   initial begin
      int en_cnt, hs, fd_cnt, fd_cyc, vcyc;
      bit early;
      logic [71:0] first_win;

      first_win = pack(0, 0, 0, 0, 1, 2, 0, 6, 7);

      // Reset with a start pulse held during reset: everything must stay at zero.
      rst = 1'b1; start = 1'b1; win_ready = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_valid", win_valid, 0);
      check("rst_pixels", win_pixels, 0);
      check("rst_row", win_row, 0);
      check("rst_col", win_col, 0);
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("idle_busy", busy, 0);
         check("idle_mem_en", mem_en, 0);
      end

      // First window: start in cycle 0, window presented in cycle 11 after exactly 4 reads.
      start = 1'b1;
      step();
      start = 1'b0;
      en_cnt = 0; early = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         en_cnt += int'(mem_en);
         if (win_valid) early = 1'b1;
         step();
      end
      check("w00_valid_cycle11", win_valid, 1);
      check("w00_no_early_valid", early, 0);
      check("w00_mem_en_count", en_cnt, 4);
      check("w00_busy", busy, 1);

      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (r != 0 || c != 0) wait_valid("win_timeout");
            check("win_row", win_row, r);
            check("win_col", win_col, c);
            check("win_pixels_model", win_pixels, exp_win(r, c));
            if (r == 0 && c == 0) check("w00_pixels", win_pixels, first_win);
            if (r == 1 && c == 1) check("w11_pixels", win_pixels, pack(1, 2, 3, 6, 7, 8, 11, 12, 13));
            if (r == 3 && c == 4) check("w34_pixels", win_pixels, pack(14, 15, 0, 19, 20, 0, 0, 0, 0));
            if (r == 0 && c == 4) check("w04_right_pad", win_pixels, pack(0, 0, 0, 4, 5, 0, 9, 10, 0));
            if (r == 1 && c == 0) check("w10_left_pad", win_pixels, pack(0, 1, 2, 0, 6, 7, 0, 11, 12));
            if (r == 0 && c == 2) begin
               for (int i = 0; i < 5; i++) begin
                  step();
                  check("bp_valid", win_valid, 1);
                  check("bp_mem_en", mem_en, 0);
                  check("bp_pixels", win_pixels, pack(0, 0, 0, 2, 3, 4, 7, 8, 9));
                  check("bp_row", win_row, 0);
                  check("bp_col", win_col, 2);
               end
            end
            win_ready = 1'b1;
            step();
            win_ready = 1'b0;
            if (r == ROWS-1 && c == COLS-1) begin
               check("fd_pulse", frame_done, 1);
               check("fd_busy_low", busy, 0);
               step();
               check("fd_single", frame_done, 0);
            end else begin
               check("post_hs_valid_low", win_valid, 0);
               check("post_hs_busy", busy, 1);
            end
         end
      end

      // Full frame with win_ready held high; a mid-frame start must be ignored.
      // frame_done lands in cycle 221, i.e. 11*20+2 cycles counting the start cycle.
      win_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      hs = 0; fd_cnt = 0; fd_cyc = -1;
      for (int cyc = 1; cyc <= 260; cyc++) begin
         if (win_valid) begin
            check("ff_row", win_row, hs / COLS);
            check("ff_col", win_col, hs % COLS);
            hs++;
         end
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         start = (cyc == 50);
         step();
      end
      start = 1'b0;
      check("ff_handshakes", hs, 20);
      check("ff_done_count", fd_cnt, 1);
      check("ff_done_cycle", fd_cyc, 221);
      check("ff_idle_busy", busy, 0);

      // Reset after the 7th handshake, then restart from (0,0).
      start = 1'b1;
      step();
      start = 1'b0;
      hs = 0;
      for (int i = 0; i < 200; i++) begin
         if (win_valid) hs++;
         if (hs == 7) break;
         step();
      end
      check("rr_seventh_hs", hs, 7);
      step();
      rst = 1'b1;
      step();
      check("rr_busy", busy, 0);
      check("rr_valid", win_valid, 0);
      check("rr_mem_en", mem_en, 0);
      check("rr_row", win_row, 0);
      check("rr_col", win_col, 0);
      check("rr_pixels", win_pixels, 0);
      rst = 1'b0; win_ready = 1'b0;
      repeat (3) step();
      check("rr_idle", busy, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      vcyc = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (win_valid) begin
            vcyc = cyc;
            break;
         end
         step();
      end
      check("rs_valid_cycle", vcyc, 11);
      check("rs_row", win_row, 0);
      check("rs_col", win_col, 0);
      check("rs_pixels", win_pixels, first_win);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
